// File: rtl/button_debouncer_pkg.sv
// Shared constants, FSM state encoding and width helper for the push-button debouncer.
// The optional auto-repeat feature is selected with the BTN_AUTOREPEAT_EN macro.
package button_debouncer_pkg;

  localparam int DEF_N_BTN           = 2;
  localparam int DEF_SYNC_STAGES     = 2;
  localparam int DEF_DEBOUNCE_CYCLES = 16;
  localparam int DEF_REPEAT_DELAY    = 64;
  localparam int DEF_REPEAT_PERIOD   = 16;

  typedef enum logic {
    ST_STABLE   = 1'b0,
    ST_CHANGING = 1'b1
  } state_t;

  // Bits needed to hold 0..value-1; never narrower than one bit.
  function automatic int clog2(input int value);
    int width;
    width = 0;
    while ((1 << width) < value) width++;
    if (width < 1) width = 1;
    return width;
  endfunction

endpackage

// File: rtl/debounce_channel.sv
// One button channel: synchroniser, STABLE/CHANGING debounce FSM and, with
// BTN_AUTOREPEAT_EN defined, a hold counter that generates auto-repeat presses.
module debounce_channel
  import button_debouncer_pkg::*;
#(
  parameter int SYNC_STAGES     = DEF_SYNC_STAGES,
  parameter int DEBOUNCE_CYCLES = DEF_DEBOUNCE_CYCLES,
  parameter int REPEAT_DELAY    = DEF_REPEAT_DELAY,
  parameter int REPEAT_PERIOD   = DEF_REPEAT_PERIOD
) (
  input  logic clk,
  input  logic rst_n,
  input  logic raw,
  output logic level,
  output logic press_pulse,
  output logic release_pulse,
  output logic press_next
);

  localparam int CNT_W = clog2(DEBOUNCE_CYCLES);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

  if (SYNC_STAGES < 2) begin : g_bad_sync
    $error("SYNC_STAGES must be at least 2");
  end
  if (DEBOUNCE_CYCLES < 2) begin : g_bad_debounce
    $error("DEBOUNCE_CYCLES must be at least 2");
  end
  if (REPEAT_PERIOD < 1 || REPEAT_PERIOD > REPEAT_DELAY) begin : g_bad_repeat
    $error("REPEAT_PERIOD must be in 1..REPEAT_DELAY");
  end

  logic [SYNC_STAGES-1:0] sync_q;
  logic                   s;
  state_t                 state_q, state_d;
  logic [CNT_W-1:0]       cnt_q, cnt_d;
  logic                   level_q, level_d;
  logic                   accept_press, accept_release;
  logic                   repeat_fire;
  logic                   press_d, release_d;

  assign s = sync_q[SYNC_STAGES-1];

  always_comb begin
    state_d        = state_q;
    cnt_d          = cnt_q;
    level_d        = level_q;
    accept_press   = 1'b0;
    accept_release = 1'b0;
    unique case (state_q)
      ST_STABLE: begin
        if (s != level_q) begin
          state_d = ST_CHANGING;
          cnt_d   = CNT_W'(1);
        end
      end
      ST_CHANGING: begin
        if (s == level_q) begin
          // Bounce back to the accepted level: discard the run.
          state_d = ST_STABLE;
          cnt_d   = '0;
        end else if (cnt_q == CNT_LAST) begin
          state_d        = ST_STABLE;
          cnt_d          = '0;
          level_d        = s;
          accept_press   = s;
          accept_release = ~s;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      default: begin
        state_d = ST_STABLE;
        cnt_d   = '0;
      end
    endcase
  end

`ifdef BTN_AUTOREPEAT_EN
  localparam int HOLD_W = clog2(REPEAT_DELAY);
  localparam logic [HOLD_W-1:0] HOLD_LAST   = HOLD_W'(REPEAT_DELAY - 1);
  localparam logic [HOLD_W-1:0] HOLD_RELOAD = HOLD_W'(REPEAT_DELAY - REPEAT_PERIOD);

  logic [HOLD_W-1:0] hold_q, hold_d;

  // Reloading to DELAY-PERIOD after each repeat spaces later pulses PERIOD apart.
  always_comb begin
    hold_d      = hold_q;
    repeat_fire = 1'b0;
    if (accept_press) begin
      hold_d = '0;
    end else if (level_q) begin
      if (hold_q == HOLD_LAST) begin
        hold_d      = HOLD_RELOAD;
        repeat_fire = ~accept_release;
      end else begin
        hold_d = hold_q + 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) hold_q <= '0;
    else        hold_q <= hold_d;
  end
`else
  assign repeat_fire = 1'b0;
`endif

  assign press_d    = accept_press | repeat_fire;
  assign release_d  = accept_release;
  assign press_next = press_d;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      sync_q        <= '0;
      state_q       <= ST_STABLE;
      cnt_q         <= '0;
      level_q       <= 1'b0;
      press_pulse   <= 1'b0;
      release_pulse <= 1'b0;
    end else begin
      sync_q        <= {sync_q[SYNC_STAGES-2:0], raw};
      state_q       <= state_d;
      cnt_q         <= cnt_d;
      level_q       <= level_d;
      press_pulse   <= press_d;
      release_pulse <= release_d;
    end
  end

  assign level = level_q;

endmodule

// File: rtl/button_debouncer.sv
// Push-button conditioner: N_BTN independent debounce channels plus a registered
// any_press strobe. Auto-repeat is enabled by defining BTN_AUTOREPEAT_EN.
module button_debouncer
  import button_debouncer_pkg::*;
#(
  parameter int N_BTN           = DEF_N_BTN,
  parameter int SYNC_STAGES     = DEF_SYNC_STAGES,
  parameter int DEBOUNCE_CYCLES = DEF_DEBOUNCE_CYCLES,
  parameter int REPEAT_DELAY    = DEF_REPEAT_DELAY,
  parameter int REPEAT_PERIOD   = DEF_REPEAT_PERIOD
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [N_BTN-1:0] btn_raw,
  output logic [N_BTN-1:0] btn_level,
  output logic [N_BTN-1:0] btn_press,
  output logic [N_BTN-1:0] btn_release,
  output logic             any_press
);

  logic [N_BTN-1:0] press_next;

  for (genvar i = 0; i < N_BTN; i++) begin : g_ch
    debounce_channel #(
      .SYNC_STAGES     (SYNC_STAGES),
      .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES),
      .REPEAT_DELAY    (REPEAT_DELAY),
      .REPEAT_PERIOD   (REPEAT_PERIOD)
    ) u_ch (
      .clk           (clk),
      .rst_n         (rst_n),
      .raw           (btn_raw[i]),
      .level         (btn_level[i]),
      .press_pulse   (btn_press[i]),
      .release_pulse (btn_release[i]),
      .press_next    (press_next[i])
    );
  end

  // Registered from the same next-state terms so it lines up with btn_press.
  always_ff @(posedge clk) begin
    if (!rst_n) any_press <= 1'b0;
    else        any_press <= |press_next;
  end

endmodule

// File: tb/tb_button_debouncer.sv
// Directed bench for button_debouncer: vector table for reset/press/release timing
// plus sequences for bounce, glitch, mid-count reset and long hold (BTN_AUTOREPEAT_EN aware).
module tb_button_debouncer;

  logic       clk;
  logic       rst_n;
  logic [1:0] btn_raw;
  logic [1:0] btn_level;
  logic [1:0] btn_press;
  logic [1:0] btn_release;
  logic       any_press;

  int checks   = 0;
  int failures = 0;
  int press_cnt [2];
  int rel_cnt   [2];
  bit mon_en    = 1'b0;

`ifdef BTN_AUTOREPEAT_EN
  localparam bit AUTOREPEAT = 1'b1;
`else
  localparam bit AUTOREPEAT = 1'b0;
`endif

  button_debouncer #(
    .N_BTN           (2),
    .SYNC_STAGES     (2),
    .DEBOUNCE_CYCLES (16),
    .REPEAT_DELAY    (64),
    .REPEAT_PERIOD   (16)
  ) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .btn_raw     (btn_raw),
    .btn_level   (btn_level),
    .btn_press   (btn_press),
    .btn_release (btn_release),
    .any_press   (any_press)
  );

  // clock / reset
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  // pulse counter and press/release exclusivity monitor
  always @(negedge clk) begin
    if (mon_en && rst_n) begin
      for (int i = 0; i < 2; i++) begin
        press_cnt[i] += int'(btn_press[i]);
        rel_cnt[i]   += int'(btn_release[i]);
      end
      checks++;
      if ((btn_press & btn_release) !== 2'b00) begin
        failures++;
        $display("FAIL press_release_overlap: press=%b release=%b", btn_press, btn_release);
      end
    end
  end

  typedef struct {
    logic [1:0] raw;
    logic       rst;
    int         n;
    logic [1:0] level;
    logic [1:0] press;
    logic [1:0] rel;
    logic       any;
  } vec_t;

  vec_t tbl[$];

  initial begin
    int p0, p1, r0, a;
    logic exp_p;

    tbl.push_back('{2'b11, 1'b0, 5,  2'b00, 2'b00, 2'b00, 1'b0}); // held through reset
    tbl.push_back('{2'b11, 1'b1, 17, 2'b00, 2'b00, 2'b00, 1'b0});
    tbl.push_back('{2'b11, 1'b1, 1,  2'b11, 2'b11, 2'b00, 1'b1});
    tbl.push_back('{2'b11, 1'b1, 1,  2'b11, 2'b00, 2'b00, 1'b0});
    tbl.push_back('{2'b00, 1'b1, 17, 2'b11, 2'b00, 2'b00, 1'b0});
    tbl.push_back('{2'b00, 1'b1, 1,  2'b00, 2'b00, 2'b11, 1'b0});
    tbl.push_back('{2'b00, 1'b1, 1,  2'b00, 2'b00, 2'b00, 1'b0});
    tbl.push_back('{2'b01, 1'b1, 17, 2'b00, 2'b00, 2'b00, 1'b0}); // clean press ch0
    tbl.push_back('{2'b01, 1'b1, 1,  2'b01, 2'b01, 2'b00, 1'b1});
    tbl.push_back('{2'b01, 1'b1, 1,  2'b01, 2'b00, 2'b00, 1'b0});
    tbl.push_back('{2'b00, 1'b1, 17, 2'b01, 2'b00, 2'b00, 1'b0});
    tbl.push_back('{2'b00, 1'b1, 1,  2'b00, 2'b00, 2'b01, 1'b0});
    tbl.push_back('{2'b00, 1'b1, 1,  2'b00, 2'b00, 2'b00, 1'b0});
    tbl.push_back('{2'b01, 1'b1, 5,  2'b00, 2'b00, 2'b00, 1'b0}); // staggered presses
    tbl.push_back('{2'b11, 1'b1, 12, 2'b00, 2'b00, 2'b00, 1'b0});
    tbl.push_back('{2'b11, 1'b1, 1,  2'b01, 2'b01, 2'b00, 1'b1});
    tbl.push_back('{2'b11, 1'b1, 4,  2'b01, 2'b00, 2'b00, 1'b0});
    tbl.push_back('{2'b11, 1'b1, 1,  2'b11, 2'b10, 2'b00, 1'b1});
    tbl.push_back('{2'b11, 1'b1, 1,  2'b11, 2'b00, 2'b00, 1'b0});
    tbl.push_back('{2'b10, 1'b1, 17, 2'b11, 2'b00, 2'b00, 1'b0});
    tbl.push_back('{2'b10, 1'b1, 1,  2'b10, 2'b00, 2'b01, 1'b0});
    tbl.push_back('{2'b10, 1'b1, 1,  2'b10, 2'b00, 2'b00, 1'b0});
    tbl.push_back('{2'b00, 1'b1, 17, 2'b10, 2'b00, 2'b00, 1'b0});
    tbl.push_back('{2'b00, 1'b1, 1,  2'b00, 2'b00, 2'b10, 1'b0});
    tbl.push_back('{2'b00, 1'b1, 1,  2'b00, 2'b00, 2'b00, 1'b0});

    for (int i = 0; i < 2; i++) begin
      press_cnt[i] = 0;
      rel_cnt[i]   = 0;
    end

    for (int v = 0; v < tbl.size(); v++) begin
      btn_raw = tbl[v].raw;
      rst_n   = tbl[v].rst;
      step(tbl[v].n);
      check($sformatf("vec%0d_level", v),   32'(btn_level),   32'(tbl[v].level));
      check($sformatf("vec%0d_press", v),   32'(btn_press),   32'(tbl[v].press));
      check($sformatf("vec%0d_release", v), 32'(btn_release), 32'(tbl[v].rel));
      check($sformatf("vec%0d_any", v),     32'(any_press),   32'(tbl[v].any));
      mon_en = 1'b1;
    end

    // bounce on ch1: 1,0,1,0 for 3 cycles each, then a steady 1
    p1 = press_cnt[1];
    for (int b = 0; b < 4; b++) begin
      btn_raw = (b % 2 == 0) ? 2'b10 : 2'b00;
      step(3);
    end
    btn_raw = 2'b10;
    step(17);
    check("bounce_no_early_press", 32'(press_cnt[1] - p1), 32'd0);
    check("bounce_level_before", 32'(btn_level), 32'h0);
    step(1);
    check("bounce_press", 32'(btn_press), 32'h2);
    check("bounce_level", 32'(btn_level), 32'h2);
    step(1);
    check("bounce_single_press", 32'(press_cnt[1] - p1), 32'd1);
    btn_raw = 2'b00;
    step(18);
    check("bounce_release", 32'(btn_release), 32'h2);
    step(2);

    // glitches shorter than the debounce window leave no trace
    p0 = press_cnt[0];
    r0 = rel_cnt[0];
    btn_raw = 2'b01;
    step(10);
    btn_raw = 2'b00;
    step(30);
    btn_raw = 2'b01;
    step(15);
    btn_raw = 2'b00;
    step(30);
    check("glitch_level", 32'(btn_level), 32'h0);
    check("glitch_press_count", 32'(press_cnt[0] - p0), 32'd0);
    check("glitch_release_count", 32'(rel_cnt[0] - r0), 32'd0);

    // a 16-cycle pulse is just long enough to be accepted
    btn_raw = 2'b01;
    step(16);
    btn_raw = 2'b00;
    step(1);
    check("pulse16_level_before", 32'(btn_level), 32'h0);
    step(1);
    check("pulse16_press", 32'(btn_press), 32'h1);
    step(15);
    check("pulse16_level_held", 32'(btn_level), 32'h1);
    step(1);
    check("pulse16_release", 32'(btn_release), 32'h1);
    check("pulse16_level_after", 32'(btn_level), 32'h0);
    step(2);

    // reset for one cycle with ch0 counter at 10
    p0 = press_cnt[0];
    btn_raw = 2'b01;
    step(12);
    rst_n = 1'b0;
    step(1);
    check("midreset_level", 32'(btn_level), 32'h0);
    check("midreset_press", 32'(btn_press), 32'h0);
    rst_n = 1'b1;
    step(17);
    check("midreset_no_early_press", 32'(press_cnt[0] - p0), 32'd0);
    check("midreset_level_before", 32'(btn_level), 32'h0);
    step(1);
    check("midreset_press_after", 32'(btn_press), 32'h1);
    check("midreset_level_after", 32'(btn_level), 32'h1);
    btn_raw = 2'b00;
    step(18);
    check("midreset_release", 32'(btn_release), 32'h1);
    step(2);

    // long hold on ch0: one press, plus repeats at +64, +80, ... when enabled
    btn_raw = 2'b01;
    step(18);
    check("hold_accept_press", 32'(btn_press), 32'h1);
    check("hold_accept_any", 32'(any_press), 32'h1);
    for (int k = 1; k <= 240; k++) begin
      step(1);
      a = k;
      exp_p = AUTOREPEAT && (a < 218) && (a >= 64) && ((a - 64) % 16 == 0);
      check($sformatf("hold_press_k%0d", a), 32'(btn_press[0]), 32'(exp_p));
      check($sformatf("hold_any_k%0d", a), 32'(any_press), 32'(exp_p));
      check($sformatf("hold_release_k%0d", a), 32'(btn_release[0]), 32'(a == 218));
      check($sformatf("hold_level_k%0d", a), 32'(btn_level[0]), 32'(a < 218));
      if (k == 200) btn_raw = 2'b00;
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
